// File: rtl/cla_addsub_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : cla_addsub_pipe_if
//  Description : Handshake and data bundle for the pipelined CLA
//                adder/subtractor.
//                Operand side : In_valid, In_ready, A, B, Sub
//                Result side  : Out_valid, Out_ready, F, Co, Ovf, Zero
//                The master modport belongs to the producer/consumer
//                environment. The slave modport belongs to the adder.
//  Revision    : 1.0  initial release
// ============================================================================
interface cla_addsub_pipe_if #(
  parameter int WIDTH = 24
);
  logic             In_valid;
  logic             In_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Sub;
  logic             Out_valid;
  logic             Out_ready;
  logic [WIDTH-1:0] F;
  logic             Co;
  logic             Ovf;
  logic             Zero;

  modport master (
    output In_valid, A, B, Sub, Out_ready,
    input  In_ready, Out_valid, F, Co, Ovf, Zero
  );

  modport slave (
    input  In_valid, A, B, Sub, Out_ready,
    output In_ready, Out_valid, F, Co, Ovf, Zero
  );
endinterface
`default_nettype wire

// File: rtl/cla_addsub_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : cla_addsub_pipe
//  Description : Pipelined carry-lookahead adder/subtractor with valid/ready
//                handshakes. The operand is cut into STAGES segments. Each
//                pipeline stage finishes one segment, and the segment carry
//                is registered between stages. Inside a segment, GROUP-bit
//                lookahead blocks ripple their carries into one another.
//  Ports       : Clk   - clock, rising edge
//                Rst_n - asynchronous active-low reset
//                bus   - cla_addsub_pipe_if.slave, carrying the operand
//                        handshake (In_valid/In_ready, A, B, Sub) and the
//                        result handshake (Out_valid/Out_ready, F, Co, Ovf,
//                        Zero)
//  Revision    : 1.0  initial release
// ============================================================================
module cla_addsub_pipe #(
  parameter int WIDTH  = 24,
  parameter int GROUP  = 4,
  parameter int STAGES = 2
) (
  input  logic                Clk,
  input  logic                Rst_n,
  cla_addsub_pipe_if.slave    bus
);

  localparam int SEG  = WIDTH / STAGES;
  localparam int NGRP = SEG / GROUP;

  // One lookahead group. Every carry is formed directly from cin and the
  // group's g/p terms (sum of products), so no carry waits on a lower one.
  // Result is {carry_out, sum}.
  function automatic logic [GROUP:0] cla_group(
    input logic [GROUP-1:0] a,
    input logic [GROUP-1:0] b,
    input logic             cin
  );
    logic [GROUP-1:0] g;
    logic [GROUP-1:0] p;
    logic [GROUP:0]   c;
    logic             term;
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < GROUP; i++) begin
      c[i+1] = cin;
      for (int j = 0; j <= i; j++) c[i+1] = c[i+1] & p[j];
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int m = j + 1; m <= i; m++) term = term & p[m];
        c[i+1] = c[i+1] | term;
      end
    end
    return {c[GROUP], p ^ c[GROUP-1:0]};
  endfunction

  // One segment: lookahead groups chained by their group carry.
  // Result is {carry_out, sum}.
  function automatic logic [SEG:0] cla_segment(
    input logic [SEG-1:0] a,
    input logic [SEG-1:0] b,
    input logic           cin
  );
    logic [SEG-1:0] s;
    logic           c;
    logic [GROUP:0] r;
    s = '0;
    c = cin;
    for (int k = 0; k < NGRP; k++) begin
      r                  = cla_group(a[k*GROUP +: GROUP], b[k*GROUP +: GROUP], c);
      s[k*GROUP +: GROUP] = r[GROUP-1:0];
      c                  = r[GROUP];
    end
    return {c, s};
  endfunction

  // Index 0 of each pipe array is the live input. Index k (k >= 1) is the
  // content registered in stage k.
  logic [STAGES:0]    v;
  logic [STAGES+1:1]  en;
  logic [WIDTH-1:0]   a_pipe [0:STAGES-1];
  logic [WIDTH-1:0]   b_pipe [0:STAGES-1];
  logic [WIDTH-1:0]   f_pipe [0:STAGES-1];
  logic [STAGES-1:0]  c_pipe;

  assign v[0]      = bus.In_valid;
  assign a_pipe[0] = bus.A;
  // Subtraction is handled as A + ~B + 1. B is inverted once, here, and the
  // +1 enters as the carry-in of segment 0.
  assign b_pipe[0] = bus.B ^ {WIDTH{bus.Sub}};
  assign f_pipe[0] = '0;
  assign c_pipe[0] = bus.Sub;

  // Back-pressure: a stage may load when it is empty or its successor loads.
  assign en[STAGES+1] = bus.Out_ready;
  assign bus.In_ready  = en[1];
  assign bus.Out_valid = v[STAGES];

  for (genvar k = 1; k <= STAGES; k++) begin : g_stage
    localparam int LO = (k - 1) * SEG;

    logic [SEG:0]     seg_res;
    logic [WIDTH-1:0] f_next;
    logic             v_q;

    assign seg_res = cla_segment(a_pipe[k-1][LO +: SEG], b_pipe[k-1][LO +: SEG], c_pipe[k-1]);

    always_comb begin
      f_next            = f_pipe[k-1];
      f_next[LO +: SEG] = seg_res[SEG-1:0];
    end

    assign en[k] = !v[k] || en[k+1];
    assign v[k]  = v_q;

    always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
        v_q <= 1'b0;
      end else if (en[k]) begin
        v_q <= v[k-1];
      end
    end

    if (k < STAGES) begin : g_mid
      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] b_q;
      logic [WIDTH-1:0] f_q;
      logic             c_q;

      always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
          a_q <= '0;
          b_q <= '0;
          f_q <= '0;
          c_q <= 1'b0;
        end else if (en[k]) begin
          a_q <= a_pipe[k-1];
          b_q <= b_pipe[k-1];
          f_q <= f_next;
          c_q <= seg_res[SEG];
        end
      end

      assign a_pipe[k] = a_q;
      assign b_pipe[k] = b_q;
      assign f_pipe[k] = f_q;
      assign c_pipe[k] = c_q;
    end else begin : g_last
      logic             ovf_next;
      logic [WIDTH-1:0] f_q;
      logic             co_q;
      logic             ovf_q;
      logic             zero_q;

      // Carry-in XOR carry-out of the MSB is true exactly when both operands
      // (B already inverted) share a sign and the sum's sign differs from it.
      assign ovf_next = (a_pipe[k-1][WIDTH-1] == b_pipe[k-1][WIDTH-1]) &&
                        (f_next[WIDTH-1] != a_pipe[k-1][WIDTH-1]);

      always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
          f_q    <= '0;
          co_q   <= 1'b0;
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else if (en[k]) begin
          f_q    <= f_next;
          co_q   <= seg_res[SEG];
          ovf_q  <= ovf_next;
          zero_q <= ~|f_next;
        end
      end

      assign bus.F    = f_q;
      assign bus.Co   = co_q;
      assign bus.Ovf  = ovf_q;
      assign bus.Zero = zero_q;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cla_addsub_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cla_addsub_pipe
//  Description : Self-checking bench for cla_addsub_pipe (24-bit, 2 stages,
//                4-bit groups). An arithmetic reference model feeds a
//                scoreboard queue, and directed vectors carry literal
//                expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cla_addsub_pipe;

  localparam int W = 24;
  localparam int G = 4;
  localparam int S = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cla_addsub_pipe_if #(.WIDTH(W)) bus ();

  cla_addsub_pipe #(.WIDTH(W), .GROUP(G), .STAGES(S)) dut (
    .Clk   (clk),
    .Rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [W-1:0] f;
    logic         co;
    logic         ovf;
    logic         zero;
  } res_t;

  res_t q[$];
  res_t sb_e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_out = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed readings of the operands.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    res_t   r;
    longint ua, ub, sa, sb, su, ss, lim;
    lim = longint'(1) << W;
    ua  = 0;
    ub  = 0;
    ua[W-1:0] = a;
    ub[W-1:0] = b;
    sa  = a[W-1] ? ua - lim : ua;
    sb  = b[W-1] ? ub - lim : ub;
    su  = sub ? ua - ub : ua + ub;
    ss  = sub ? sa - sb : sa + sb;
    r.f    = su[W-1:0];
    r.co   = sub ? (ua >= ub) : (su >= lim);
    r.ovf  = (ss >= lim / 2) || (ss < -(lim / 2));
    r.zero = (r.f == '0);
    return r;
  endfunction

  // Scoreboard: every transfer-in enqueues a model result, and every transfer-out is compared.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      if (bus.Out_valid && bus.Out_ready) begin
        n_out++;
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL sb_unexpected: got result %h expected none", bus.F);
        end else begin
          sb_e = q.pop_front();
          check("sb_F",    bus.F,    sb_e.f);
          check("sb_Co",   W'(bus.Co),   W'(sb_e.co));
          check("sb_Ovf",  W'(bus.Ovf),  W'(sb_e.ovf));
          check("sb_Zero", W'(bus.Zero), W'(sb_e.zero));
        end
      end
      if (bus.In_valid && bus.In_ready)
        q.push_back(model(bus.A, bus.B, bus.Sub));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One operation with literal expectations, including the latency check.
  task automatic op_check(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sub, input logic [W-1:0] ef, input logic eco,
                          input logic eovf, input logic ez);
    int lat;
    bus.In_valid  = 1'b1;
    bus.A         = a;
    bus.B         = b;
    bus.Sub       = sub;
    bus.Out_ready = 1'b1;
    @(negedge clk);
    check({name, "_in_ready"}, W'(bus.In_ready), W'(1'b1));
    tick();
    bus.In_valid = 1'b0;
    lat = 0;
    @(negedge clk);
    while (!bus.Out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_latency"}, W'(lat), W'(S - 1));
    check({name, "_F"},    bus.F,         ef);
    check({name, "_Co"},   W'(bus.Co),    W'(eco));
    check({name, "_Ovf"},  W'(bus.Ovf),   W'(eovf));
    check({name, "_Zero"}, W'(bus.Zero),  W'(ez));
    tick();
  endtask

  task automatic drain();
    int t;
    bus.In_valid  = 1'b0;
    bus.Out_ready = 1'b1;
    t = 0;
    while ((q.size() != 0 || bus.Out_valid) && t < 50) begin
      tick();
      t++;
    end
    check("drain_left", W'(q.size()), '0);
  endtask

  function automatic logic [W-1:0] rand_op();
    logic [W-1:0] x;
    case ($urandom_range(0, 4))
      0:       x = '0;
      1:       x = '1;
      2:       x = {1'b1, {(W-1){1'b0}}};
      3:       x = {1'b0, {(W-1){1'b1}}};
      default: x = W'($urandom);
    endcase
    return x;
  endfunction

  logic [W-1:0] bp_a [0:7];
  logic [W-1:0] bp_b [0:7];
  logic         bp_s [0:7];
  res_t         first_exp;
  int           idx;
  int           out0;
  logic         took;

  initial begin
    bus.In_valid  = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.Sub       = 1'b0;
    bus.Out_ready = 1'b1;

    // Reset state
    #2;
    check("rst_Out_valid", W'(bus.Out_valid), '0);
    check("rst_F",         bus.F,             '0);
    check("rst_Co",        W'(bus.Co),        '0);
    check("rst_Ovf",       W'(bus.Ovf),       '0);
    check("rst_Zero",      W'(bus.Zero),      '0);
    check("rst_In_ready",  W'(bus.In_ready),  W'(1'b1));
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Directed vectors
    op_check("add_ovf",   24'h7FFFFF, 24'h000001, 1'b0, 24'h800000, 1'b0, 1'b1, 1'b0);
    op_check("sub_eq",    24'h000005, 24'h000005, 1'b1, 24'h000000, 1'b1, 1'b0, 1'b1);
    op_check("sub_neg",   24'h000003, 24'h000005, 1'b1, 24'hFFFFFE, 1'b0, 1'b0, 1'b0);
    op_check("add_grp",   24'h000FFF, 24'h000001, 1'b0, 24'h001000, 1'b0, 1'b0, 1'b0);
    op_check("add_seg",   24'h000800, 24'h000800, 1'b0, 24'h001000, 1'b0, 1'b0, 1'b0);
    op_check("add_wrap",  24'hFFFFFF, 24'h000001, 1'b0, 24'h000000, 1'b1, 1'b0, 1'b1);
    op_check("sub_min",   24'h800000, 24'h000001, 1'b1, 24'h7FFFFF, 1'b1, 1'b1, 1'b0);
    op_check("sub_negov", 24'h7FFFFF, 24'hFFFFFF, 1'b1, 24'h800000, 1'b0, 1'b1, 1'b0);

    // Back-pressure: fill with Out_ready low, then release.
    for (int i = 0; i < 8; i++) begin
      bp_a[i] = W'(i * 24'h111111);
      bp_b[i] = 24'h0F0F0F ^ W'(i);
      bp_s[i] = i[0];
    end
    first_exp     = model(bp_a[0], bp_b[0], bp_s[0]);
    out0          = n_out;
    bus.Out_ready = 1'b0;
    idx           = 0;
    for (int c = 0; c < 6; c++) begin
      bus.In_valid = 1'b1;
      bus.A        = bp_a[idx];
      bus.B        = bp_b[idx];
      bus.Sub      = bp_s[idx];
      @(negedge clk);
      took = bus.In_ready;
      tick();
      if (took) idx++;
    end
    @(negedge clk);
    check("bp_accepts",   W'(idx),           W'(S));
    check("bp_In_ready",  W'(bus.In_ready),  '0);
    check("bp_Out_valid", W'(bus.Out_valid), W'(1'b1));
    for (int c = 0; c < 3; c++) begin
      check("bp_F_hold", bus.F, first_exp.f);
      @(negedge clk);
    end
    tick();
    bus.Out_ready = 1'b1;
    while (idx < 8) begin
      bus.In_valid = 1'b1;
      bus.A        = bp_a[idx];
      bus.B        = bp_b[idx];
      bus.Sub      = bp_s[idx];
      @(negedge clk);
      check("bp_throughput", W'(bus.In_ready), W'(1'b1));
      tick();
      idx++;
    end
    drain();
    check("bp_count", W'(n_out - out0), W'(8));

    // Reset with two results in flight
    bus.Out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.In_valid = 1'b1;
      bus.A        = bp_a[i + 3];
      bus.B        = bp_b[i + 3];
      bus.Sub      = bp_s[i + 3];
      tick();
    end
    bus.In_valid = 1'b0;
    @(negedge clk);
    check("mid_full", W'(bus.Out_valid), W'(1'b1));
    rst_n = 1'b0;
    #1;
    check("mid_rst_Out_valid", W'(bus.Out_valid), '0);
    check("mid_rst_F",         bus.F,             '0);
    check("mid_rst_In_ready",  W'(bus.In_ready),  W'(1'b1));
    tick();
    rst_n         = 1'b1;
    bus.Out_ready = 1'b1;
    out0          = n_out;
    repeat (6) tick();
    check("mid_no_stale", W'(n_out - out0), '0);
    check("mid_In_ready", W'(bus.In_ready), W'(1'b1));

    // Random valid/ready toggling
    out0 = n_out;
    for (int c = 0; c < 400; c++) begin
      bus.In_valid  = ($urandom_range(0, 3) != 0);
      bus.A         = rand_op();
      bus.B         = rand_op();
      bus.Sub       = $urandom_range(0, 1) == 1;
      bus.Out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    drain();
    n_cmp++;
    if (n_out - out0 < 50) begin
      n_err++;
      $display("FAIL rnd_volume: got %0d results expected at least 50", n_out - out0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
